// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester scheduler for the shared combinational
// SLL/SRA shift datapath. It selects at most one requester per cycle and
// drives that requester's operand, shift amount and op onto the shifter
// ports. The shifter result is captured into a one-entry response register
// that carries the requester ID.
//
// Build option: define SHIFT_ARB_FIXED_PRI_EN to select fixed priority, where
// requester 0 always wins a tie and no grant history is kept. When it is left
// undefined, ties are resolved round-robin.
module shift_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*SHW-1:0]     req_shamt,
  input  logic [1:0]           req_op,
  output logic [WIDTH-1:0]     sh_a,
  output logic [SHW-1:0]       sh_shamt,
  output logic                 sh_op,
  input  logic [WIDTH-1:0]     sh_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_id
);

  logic slot_free;
  logic sel_valid;
  logic sel_id;
  logic fire;

`ifdef SHIFT_ARB_FIXED_PRI_EN
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    sel_valid = |req_valid;
    sel_id    = ~req_valid[0] & req_valid[1];
  end
`else
  logic last_grant;

  // Round-robin: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    sel_valid = |req_valid;
    sel_id    = 1'b0;
    case (req_valid)
      2'b10:   sel_id = 1'b1;
      2'b11:   sel_id = ~last_grant;
      default: sel_id = 1'b0;
    endcase
  end

  // Grant history moves only on accepted requests, so a stall leaves it untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (fire) begin
      last_grant <= sel_id;
    end
  end
`endif

  // Accept when the response slot is empty or is being drained this cycle.
  always_comb begin
    slot_free = ~rsp_valid | rsp_ready;
    req_ready = '0;
    if (slot_free && sel_valid && !reset) begin
      req_ready[sel_id] = 1'b1;
    end
    fire = |req_ready;
  end

  // Steer the selected requester onto the shifter; idle inputs are zero.
  always_comb begin
    sh_a     = '0;
    sh_shamt = '0;
    sh_op    = 1'b0;
    if (sel_valid) begin
      if (sel_id) begin
        sh_a     = req_a[2*WIDTH-1:WIDTH];
        sh_shamt = req_shamt[2*SHW-1:SHW];
        sh_op    = req_op[1];
      end else begin
        sh_a     = req_a[WIDTH-1:0];
        sh_shamt = req_shamt[SHW-1:0];
        sh_op    = req_op[0];
      end
    end
  end

  // One-entry response register: load on fire, otherwise clear valid when drained.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sh_result;
      rsp_id    <= sel_id;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Two-requester round-robin scheduler for the shared combinational 32-bit shift datapath (SLL/SRA barrel shifter) in the simple ALU. Each cycle it picks at most one requester and drives that requester's operand, shift amount and op onto the shifter ports. It captures the shifter result into a one-entry response register tagged with the requester ID. Throughput is one shift per cycle, latency is one cycle, and backpressure is honoured on the response side.

Parameters:
WIDTH, 32, data width of operand and result
SHW, 5, shift-amount width (must equal log2(WIDTH))

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  2  bit i: requester i presents a request
req_ready  out  2  bit i: requester i's request is accepted this cycle
req_a  in  2*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
req_shamt  in  2*SHW  shift amounts; requester i occupies bits [i*SHW +: SHW]
req_op  in  2  bit i: requester i op, 0=SLL, 1=SRA
sh_a  out  WIDTH  operand driven to shifter
sh_shamt  out  SHW  shift amount driven to shifter
sh_op  out  1  op driven to shifter
sh_result  in  WIDTH  combinational shifter result for the current sh_* values
rsp_valid  out  1  response register holds a result
rsp_ready  in  1  consumer accepts the response this cycle
rsp_data  out  WIDTH  shift result
rsp_id  out  1  requester that issued this result

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous, active-high (reset). No asynchronous reset anywhere.
- Reset state: rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (so requester 0 wins the first contention). While reset is high, req_ready=2'b00.
- slot_free = !rsp_valid | rsp_ready. This is a combinational pass-through, so a full register that is being drained can accept a new request in the same cycle.
- Selection, combinational:
  - Only one req_valid set: select that requester.
  - Both set: select !last_grant.
  - None set: no selection.
- req_ready[i] = slot_free & selected==i & !reset. At most one bit is high. req_ready may depend on req_valid.
- fire = any req_ready bit high.
- Shifter drive:
  - sh_a, sh_shamt and sh_op are muxed from the selected requester.
  - With no selection they are driven to 0.
  - They are purely combinational. The block has no internal shifter.
- On a rising edge with fire: rsp_data<=sh_result, rsp_id<=selected, rsp_valid<=1, last_grant<=selected.
- On an edge with rsp_valid & rsp_ready and no fire: rsp_valid<=0. rsp_data and rsp_id are held.
- Stall (rsp_valid & !rsp_ready): rsp_valid, rsp_data and rsp_id stay stable, req_ready=0, and last_grant is unchanged.
- Latency: request fires at edge N, result is visible after edge N, and can be consumed at edge N+1. Back-to-back fires are allowed every cycle while rsp_ready=1.
- Fairness: under continuous dual requests with no stall, grants alternate 0,1,0,1,... A requester waits at most one accepted transaction.
- A requester must hold req_a, req_shamt and req_op stable while req_valid is high and it is not accepted. The block does not check this.
- Boundary cases:
  - shamt=0: result equals operand.
  - shamt=WIDTH-1 is legal.
  - SRA of a negative operand sign-fills (this is a shifter property; the arbiter passes it through unmodified).
- Reset mid-operation: a pending response is discarded (rsp_valid<=0) and last_grant returns to 1. Requests presented during reset are not accepted.
- No combinational path from rsp_data to any input other than through the register.

Optional Feature:
SHIFT_ARB_FIXED_PRI_EN
- Defined: fixed priority, requester 0 always wins when both are valid. last_grant is not implemented; the port list is unchanged.
- Undefined (default): round-robin as specified above.

Test Plan:
1. Reset, then req_valid=01, req_a[0]=0x80000000, shamt=4, op=SRA, rsp_ready=1 -> req_ready=01 in the same cycle; after one edge rsp_valid=1, rsp_data=0xF8000000, rsp_id=0.
2. Requester 1 alone: a=0x00000001, shamt=31, op=SLL -> rsp_data=0x80000000, rsp_id=1. Then shamt=0, a=0x12345678 -> rsp_data=0x12345678.
3. Both valid continuously for 6 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1 with rsp_valid high every cycle after the first edge. With SHIFT_ARB_FIXED_PRI_EN defined the sequence is 0,0,0,0,0,0.
4. Response valid, rsp_ready=0 for 3 cycles with both requesters valid -> req_ready=00 and rsp_data/rsp_id unchanged. Raise rsp_ready -> the old response is consumed and a new request fires in the same cycle, granted to the requester not last granted.
5. Assert reset for one cycle while rsp_valid=1 and rsp_ready=0 -> after the edge rsp_valid=0 and rsp_data=0. With both requesters valid afterwards, the first grant goes to requester 0.
6. Random traffic for 10k cycles (random valid, op, shamt, rsp_ready) against a scoreboard with a reference SLL/SRA model -> every accepted request produces exactly one response, in order, with the correct data and id, and neither requester waits more than one accepted transaction while the other requester is valid.
